vid_stream: RTL

Parametrised raster video controller for the RISC5 SRAM framebuffer: generates programmable sync/blank timing, prefetches framebuffer words through a req/ack memory port into a small FIFO, and serialises them as 1/2/4/8-bit pixels. It runs in one clock domain with a pixel-enable strobe, so no DCM is needed. It sits between the SRAM arbiter (video read port) and the display pins or palette.

---
 rtl/vid_stream.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/vid_stream.sv
// vid_stream: raster video controller for a bottom-up SRAM framebuffer.
// Generates sync/blank timing on a pixel-enable strobe. Prefetches framebuffer
// words through a req/ack read port into a small FIFO. Serialises each word
// LSB-first as BPP-bit pixels.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   pen       pixel enable; timing and pixels advance only when high
//   inv       invert pixel bits during active video
//   req/adr   memory read request and word address (adr stable while req=1)
//   ack/rdata read completion and returned word
//   hsync     registered horizontal sync at HS_POL
//   vsync     registered vertical sync at VS_POL
//   de        registered display enable
//   pix       registered pixel value, 0 outside active video
//   underrun  sticky FIFO-underrun flag, cleared at frame restart
module vid_stream #(
    parameter int unsigned H_ACT  = 1024,
    parameter int unsigned H_FP   = 62,
    parameter int unsigned H_SYNC = 104,
    parameter int unsigned H_BP   = 154,
    parameter int unsigned V_ACT  = 768,
    parameter int unsigned V_FP   = 3,
    parameter int unsigned V_SYNC = 5,
    parameter int unsigned V_BP   = 26,
    parameter bit          HS_POL = 1'b0,
    parameter bit          VS_POL = 1'b1,
    parameter int unsigned BPP    = 1,
    parameter int unsigned ADR_W  = 18,
    parameter logic [ADR_W-1:0] ORG = 18'h37FC0,
    parameter int unsigned DEPTH  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pen,
    input  logic             inv,
    output logic             req,
    output logic [ADR_W-1:0] adr,
    input  logic             ack,
    input  logic [31:0]      rdata,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [BPP-1:0]   pix,
    output logic             underrun
);

    localparam int unsigned HT   = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int unsigned VT   = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW   = $clog2(HT);
    localparam int unsigned VW   = $clog2(VT);
    localparam int unsigned H_SS = H_ACT + H_FP;
    localparam int unsigned H_SE = H_SS + H_SYNC;
    localparam int unsigned V_SS = V_ACT + V_FP;
    localparam int unsigned V_SE = V_SS + V_SYNC;
    localparam int unsigned WPL  = H_ACT * BPP / 32;
    localparam int unsigned WW   = (WPL > 1) ? $clog2(WPL) : 1;
    localparam int unsigned LW   = (V_ACT > 1) ? $clog2(V_ACT) : 1;
    localparam int unsigned FAW  = $clog2(DEPTH);
    localparam int unsigned CW   = FAW + 1;
    localparam int unsigned PSH  = $clog2(32 / BPP);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_DONE} state_t;

    logic [HW-1:0]    hcnt;
    logic [VW-1:0]    vcnt;
    logic             act_c;
    logic             hs_on_c;
    logic             vs_on_c;
    logic             restart_c;
    logic             load_c;
    logic             fifo_empty_c;
    logic             pop_c;
    logic             push_c;
    logic [31:0]      load_word_c;

    state_t           state;
    logic             stale;
    logic [WW-1:0]    word_idx;
    logic [LW-1:0]    line_idx;
    logic [ADR_W-1:0] line_base;
    logic [ADR_W-1:0] cur_adr;

    logic [31:0]      mem [DEPTH];
    logic [FAW-1:0]   wp;
    logic [FAW-1:0]   rp;
    logic [CW-1:0]    fcnt;
    logic [31:0]      sr;

    // Region decodes from the current counter state
    assign act_c     = (hcnt < HW'(H_ACT)) && (vcnt < VW'(V_ACT));
    assign hs_on_c   = (hcnt >= HW'(H_SS)) && (hcnt < HW'(H_SE));
    assign vs_on_c   = (vcnt >= VW'(V_SS)) && (vcnt < VW'(V_SE));
    assign restart_c = pen && (vcnt == VW'(VT - 1)) && (hcnt == '0);

    // A new word is needed at every 32-bit boundary of the active line
    assign load_c       = pen && act_c && (hcnt[PSH-1:0] == '0);
    assign fifo_empty_c = (fcnt == '0);
    assign pop_c        = load_c && !fifo_empty_c;
    assign load_word_c  = fifo_empty_c ? 32'd0 : mem[rp];

    // Data from a request that straddled a frame restart is dropped
    assign push_c = (state == S_WAIT) && ack && !stale && !restart_c;

    // Raster counters; vcnt resets to the last line so the first pen restarts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt <= '0;
            vcnt <= VW'(VT - 1);
        end else if (pen) begin
            if (hcnt == HW'(HT - 1)) begin
                hcnt <= '0;
                vcnt <= (vcnt == VW'(VT - 1)) ? '0 : vcnt + VW'(1);
            end else begin
                hcnt <= hcnt + HW'(1);
            end
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wp] <= rdata;
        end
    end

    // FIFO pointers and occupancy; restart flushes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp   <= '0;
            rp   <= '0;
            fcnt <= '0;
        end else if (restart_c) begin
            wp   <= '0;
            rp   <= '0;
            fcnt <= '0;
        end else begin
            if (push_c) begin
                wp <= wp + FAW'(1);
            end
            if (pop_c) begin
                rp <= rp + FAW'(1);
            end
            fcnt <= fcnt + CW'(push_c) - CW'(pop_c);
        end
    end

    // Fetch engine: one outstanding request, address walked incrementally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            stale     <= 1'b0;
            req       <= 1'b0;
            adr       <= '0;
            word_idx  <= '0;
            line_idx  <= '0;
            line_base <= '0;
            cur_adr   <= '0;
        end else if (restart_c) begin
            word_idx  <= '0;
            line_idx  <= '0;
            line_base <= ORG;
            cur_adr   <= ORG;
            if (state == S_WAIT && !ack) begin
                // keep the old request up until its ack, then discard it
                stale <= 1'b1;
            end else begin
                stale <= 1'b0;
                req   <= 1'b0;
                state <= S_FETCH;
            end
        end else begin
            case (state)
                S_IDLE: begin
                end
                S_FETCH: begin
                    if (fcnt < CW'(DEPTH)) begin
                        req   <= 1'b1;
                        adr   <= cur_adr;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ack) begin
                        req <= 1'b0;
                        if (stale) begin
                            stale <= 1'b0;
                            state <= S_FETCH;
                        end else if (word_idx == WW'(WPL - 1)) begin
                            word_idx <= '0;
                            if (line_idx == LW'(V_ACT - 1)) begin
                                state <= S_DONE;
                            end else begin
                                // lines are stored bottom-up
                                line_idx  <= line_idx + LW'(1);
                                line_base <= line_base - ADR_W'(WPL);
                                cur_adr   <= line_base - ADR_W'(WPL);
                                state     <= S_FETCH;
                            end
                        end else begin
                            word_idx <= word_idx + WW'(1);
                            cur_adr  <= cur_adr + ADR_W'(1);
                            state    <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Registered video outputs and pixel shifter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hsync    <= !HS_POL;
            vsync    <= !VS_POL;
            de       <= 1'b0;
            pix      <= '0;
            sr       <= '0;
            underrun <= 1'b0;
        end else if (pen) begin
            hsync <= hs_on_c ? HS_POL : !HS_POL;
            vsync <= vs_on_c ? VS_POL : !VS_POL;
            de    <= act_c;
            if (restart_c) begin
                underrun <= 1'b0;
            end else if (load_c && fifo_empty_c) begin
                underrun <= 1'b1;
            end
            if (load_c) begin
                pix <= load_word_c[BPP-1:0] ^ {BPP{inv}};
                sr  <= load_word_c >> BPP;
            end else if (act_c) begin
                pix <= sr[BPP-1:0] ^ {BPP{inv}};
                sr  <= sr >> BPP;
            end else begin
                pix <= '0;
            end
        end
    end

endmodule
